// File: rtl/regfile_seq.sv
// regfile_seq: operand-fetch / writeback sequencer for a 3-read / 1-write register file.
//   Accepts one (rs1, rs2, rd, wb) request, drives the read addresses, captures the
//   operands after RD_LAT cycles, hands them to the ALU via op_valid/op_ready, and
//   optionally performs a single writeback to rd.
//   Ports: clk, rst_n (async active-low) | req_* from decode | op_* to ALU |
//   wb_* from ALU | rf_* to/from the register file | busy, wr_cnt status.
module regfile_seq #(
  parameter int DW               = 16,
  parameter int AW               = 4,
  parameter int RD_LAT           = 1,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic [AW-1:0] req_rd,
  input  logic          req_wb,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [DW-1:0] op_c,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] rf_address1,
  output logic [AW-1:0] rf_address2,
  output logic [AW-1:0] rf_address3,
  output logic [DW-1:0] rf_din,
  output logic          rf_wen,
  input  logic [DW-1:0] rf_dout1,
  input  logic [DW-1:0] rf_dout2,
  input  logic [DW-1:0] rf_dout3,
  output logic          busy,
  output logic [15:0]   wr_cnt
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, RD_WAIT, OP_HOLD, WB_WAIT, WB_WRITE} state_t;
  state_t        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          wb_q, wb_d;
  logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic          op_valid_q, op_valid_d;
  logic [DW-1:0] din_q, din_d;
  logic          wen_q, wen_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    wb_d       = wb_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addr3_d    = addr3_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_c_d     = op_c_q;
    op_valid_d = op_valid_q;
    din_d      = din_q;
    wen_d      = wen_q;
    wr_cnt_d   = wr_cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr1_d   = req_rs1;
        addr2_d   = req_rs2;
        addr3_d   = req_rd;
        wb_d      = req_wb;
        lat_cnt_d = LW'(RD_LAT - 1);
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (lat_cnt_q == '0) begin
        op_a_d     = rf_dout1;
        op_b_d     = rf_dout2;
        op_c_d     = rf_dout3;
        op_valid_d = 1'b1;
        state_d    = OP_HOLD;
      end else begin
        lat_cnt_d = lat_cnt_q - 1'b1;
      end
      OP_HOLD: if (op_ready) begin
        op_valid_d = 1'b0;
        state_d    = wb_q ? WB_WAIT : IDLE;
      end
      WB_WAIT: if (wb_valid) begin
        din_d   = wb_data;
        // r0 is hard-wired to zero when protection is on: the cycle still runs, the write does not
        wen_d   = !((ZERO_REG_PROTECT != 0) && (addr3_q == '0));
        state_d = WB_WRITE;
      end
      WB_WRITE: begin
        wen_d    = 1'b0;
        wr_cnt_d = (wen_q && (wr_cnt_q != 16'hFFFF)) ? wr_cnt_q + 16'd1 : wr_cnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      wb_q       <= 1'b0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr3_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      op_valid_q <= 1'b0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      wb_q       <= wb_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr3_q    <= addr3_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_c_q     <= op_c_d;
      op_valid_q <= op_valid_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end
  assign req_ready   = (state_q == IDLE);
  assign wb_ready    = (state_q == WB_WAIT);
  assign busy        = (state_q != IDLE);
  assign op_valid    = op_valid_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_c        = op_c_q;
  assign rf_address1 = addr1_q;
  assign rf_address2 = addr2_q;
  assign rf_address3 = addr3_q;
  assign rf_din      = din_q;
  assign rf_wen      = wen_q;
  assign wr_cnt      = wr_cnt_q;
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: two sequencers (RD_LAT 1 and 2) on shared stimulus, each with a register file and a reference model
module tb_regfile_seq;
  logic        clk, rst_n;
  logic        req_valid, req_wb, op_ready, wb_valid;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic [15:0] wb_data;
  logic        req_ready [2];
  logic        op_valid [2];
  logic        wb_ready [2];
  logic        rf_wen [2];
  logic        busy [2];
  logic [15:0] op_a [2];
  logic [15:0] op_b [2];
  logic [15:0] op_c [2];
  logic [15:0] rf_din [2];
  logic [15:0] wr_cnt [2];
  logic [3:0]  rf_address1 [2];
  logic [3:0]  rf_address2 [2];
  logic [3:0]  rf_address3 [2];
  int n_pass = 0;
  int n_total = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] init_val(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    case (k)
      0: return 16'h0000;
      1: return 16'h09e4;
      2: return 16'hc61b;
      5: return 16'h0014;
      default: return (kk * 16'h0101) ^ 16'h5a5a;
    endcase
  endfunction
  task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] actual=%h expected=%h at %0t", nm, inst, act, exp, $time);
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int L = g + 1;
    logic [15:0] d1, d2, d3;
    logic [15:0] rm [16];
    int          ph, age;
    logic [3:0]  e1, e2, e3;
    logic        ewb, eopv, ewen;
    logic [15:0] ea, eb, ec, edin, ecnt;
    regfile_seq #(.DW(16), .AW(4), .RD_LAT(L), .ZERO_REG_PROTECT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
      .op_valid(op_valid[g]), .op_ready(op_ready),
      .op_a(op_a[g]), .op_b(op_b[g]), .op_c(op_c[g]),
      .wb_valid(wb_valid), .wb_ready(wb_ready[g]), .wb_data(wb_data),
      .rf_address1(rf_address1[g]), .rf_address2(rf_address2[g]), .rf_address3(rf_address3[g]),
      .rf_din(rf_din[g]), .rf_wen(rf_wen[g]),
      .rf_dout1(d1), .rf_dout2(d2), .rf_dout3(d3),
      .busy(busy[g]), .wr_cnt(wr_cnt[g])
    );
    // register file: writes and reads on the falling edge
    initial begin : rf
      logic [15:0] mem [16];
      for (int k = 0; k < 16; k++) mem[k] = init_val(k);
      d1 = '0; d2 = '0; d3 = '0;
      forever begin
        @(negedge clk);
        if (rf_wen[g]) mem[rf_address3[g]] = rf_din[g];
        d1 = mem[rf_address1[g]];
        d2 = mem[rf_address2[g]];
        d3 = mem[rf_address3[g]];
      end
    end
    // reference: one transaction at a time, phases 0 idle,1 reading,2 operands offered,3 awaiting wb,4 writing
    initial begin : model
      for (int k = 0; k < 16; k++) rm[k] = init_val(k);
      ph = 0; age = 0; e1 = '0; e2 = '0; e3 = '0; ewb = 0; eopv = 0; ewen = 0;
      ea = '0; eb = '0; ec = '0; edin = '0; ecnt = '0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          ph = 0; e1 = '0; e2 = '0; e3 = '0; eopv = 0; ewen = 0; edin = '0; ecnt = '0;
        end else begin
          case (ph)
            0: if (req_valid) begin
              e1 = req_rs1; e2 = req_rs2; e3 = req_rd; ewb = req_wb; age = 0; ph = 1;
            end
            1: begin
              age++;
              if (age == L) begin
                ea = rm[e1]; eb = rm[e2]; ec = rm[e3]; eopv = 1; ph = 2;
              end
            end
            2: if (op_ready) begin
              eopv = 0; ph = ewb ? 3 : 0;
            end
            3: if (wb_valid) begin
              edin = wb_data; ewen = (e3 != 0); ph = 4;
            end
            default: begin
              if (ewen) begin
                rm[e3] = edin;
                if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
              end
              ewen = 0; ph = 0;
            end
          endcase
        end
      end
    end
    initial begin : cmp
      forever begin
        @(negedge clk);
        chk("req_ready", g, 16'(req_ready[g]), 16'(ph == 0));
        chk("busy", g, 16'(busy[g]), 16'(ph != 0));
        chk("wb_ready", g, 16'(wb_ready[g]), 16'(ph == 3));
        chk("op_valid", g, 16'(op_valid[g]), 16'(eopv));
        chk("rf_wen", g, 16'(rf_wen[g]), 16'(ewen));
        chk("wr_cnt", g, wr_cnt[g], ecnt);
        chk("rf_address1", g, 16'(rf_address1[g]), 16'(e1));
        chk("rf_address2", g, 16'(rf_address2[g]), 16'(e2));
        chk("rf_address3", g, 16'(rf_address3[g]), 16'(e3));
        chk("rf_din", g, rf_din[g], edin);
        if (eopv) begin
          chk("op_a", g, op_a[g], ea);
          chk("op_b", g, op_b[g], eb);
          chk("op_c", g, op_c[g], ec);
        end
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b; req_rd = d; req_wb = w;
  endtask
  task automatic wait_idle;
    int n;
    n = 0;
    req_valid = 1'b0; op_ready = 1'b1; wb_valid = 1'b1;
    while (!(req_ready[0] && req_ready[1]) && n < 20) begin
      step;
      n++;
    end
    chk("idle_timeout", 0, 16'(n < 20), 16'd1);
    wb_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 0; req_wb = 0; op_ready = 0; wb_valid = 0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; wb_data = '0;
    step;
    chk("rst_op_valid", 0, 16'(op_valid[0]), 16'd0);
    chk("rst_rf_wen", 0, 16'(rf_wen[0]), 16'd0);
    chk("rst_req_ready", 0, 16'(req_ready[0]), 16'd1);
    step;
    rst_n = 1'b1;
    step;
    // basic read, no writeback; second instance shows the two-cycle latency
    op_ready = 1'b1;
    req(4'd1, 4'd2, 4'd5, 1'b0);
    step;
    req_valid = 1'b0;
    chk("t1_opv_early", 0, 16'(op_valid[0]), 16'd0);
    step;
    chk("t1_opv", 0, 16'(op_valid[0]), 16'd1);
    chk("t1_op_a", 0, op_a[0], 16'h09e4);
    chk("t1_op_b", 0, op_b[0], 16'hc61b);
    chk("t1_op_c", 0, op_c[0], 16'h0014);
    chk("t6_opv_early", 1, 16'(op_valid[1]), 16'd0);
    step;
    chk("t1_idle", 0, 16'(req_ready[0]), 16'd1);
    chk("t6_opv", 1, 16'(op_valid[1]), 16'd1);
    chk("t6_op_a", 1, op_a[1], 16'h09e4);
    step;
    // writeback to r3, then read it back
    wait_idle;
    req(4'd5, 4'd6, 4'd3, 1'b1);
    step;
    req_valid = 1'b0;
    step;
    step;
    chk("t2_wb_ready", 0, 16'(wb_ready[0]), 16'd1);
    wb_valid = 1'b1; wb_data = 16'h1234;
    step;
    chk("t2_wen", 0, 16'(rf_wen[0]), 16'd1);
    chk("t2_addr3", 0, 16'(rf_address3[0]), 16'd3);
    chk("t2_din", 0, rf_din[0], 16'h1234);
    wb_valid = 1'b0;
    step;
    chk("t2_wen_off", 0, 16'(rf_wen[0]), 16'd0);
    chk("t2_wr_cnt", 0, wr_cnt[0], 16'd1);
    req(4'd3, 4'd0, 4'd0, 1'b0);
    step;
    req_valid = 1'b0;
    step;
    chk("t2_readback", 0, op_a[0], 16'h1234);
    // ALU stall with a competing request held on the input
    wait_idle;
    op_ready = 1'b0;
    req(4'd3, 4'd5, 4'd3, 1'b0);
    step;
    req_rs1 = 4'd7;
    step;
    for (int i = 0; i < 5; i++) begin
      chk("t3_opv", 0, 16'(op_valid[0]), 16'd1);
      chk("t3_op_a", 0, op_a[0], 16'h1234);
      chk("t3_op_b", 0, op_b[0], 16'h0014);
      chk("t3_op_c", 0, op_c[0], 16'h1234);
      chk("t3_addr1", 0, 16'(rf_address1[0]), 16'd3);
      chk("t3_req_ready", 0, 16'(req_ready[0]), 16'd0);
      step;
    end
    op_ready = 1'b1; req_valid = 1'b0;
    step;
    // write to r0 is suppressed
    wait_idle;
    req(4'd0, 4'd0, 4'd0, 1'b1);
    step;
    req_valid = 1'b0;
    step;
    step;
    wb_valid = 1'b1; wb_data = 16'hffff;
    step;
    chk("t4_wen", 0, 16'(rf_wen[0]), 16'd0);
    wb_valid = 1'b0;
    step;
    chk("t4_idle", 0, 16'(req_ready[0]), 16'd1);
    chk("t4_wr_cnt", 0, wr_cnt[0], 16'd1);
    req(4'd0, 4'd9, 4'd0, 1'b0);
    step;
    req_valid = 1'b0;
    step;
    chk("t4_r0", 0, op_a[0], 16'h0000);
    // reset during the write cycle drops the write
    wait_idle;
    req(4'd1, 4'd2, 4'd4, 1'b1);
    step;
    req_valid = 1'b0;
    step;
    step;
    wb_valid = 1'b1; wb_data = 16'habcd;
    step;
    chk("t5_wen", 0, 16'(rf_wen[0]), 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_wen_rst", 0, 16'(rf_wen[0]), 16'd0);
    chk("t5_opv_rst", 0, 16'(op_valid[0]), 16'd0);
    chk("t5_cnt_rst", 0, wr_cnt[0], 16'd0);
    chk("t5_addr3_rst", 0, 16'(rf_address3[0]), 16'd0);
    chk("t5_din_rst", 0, rf_din[0], 16'd0);
    wb_valid = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    chk("t5_ready", 0, 16'(req_ready[0]), 16'd1);
    req(4'd4, 4'd0, 4'd0, 1'b0);
    step;
    req_valid = 1'b0;
    step;
    chk("t5_r4_kept", 0, op_a[0], 16'h5e5e);
    step;
    // random traffic checked by the reference models
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_rs1 = 4'($urandom); req_rs2 = 4'($urandom); req_rd = 4'($urandom);
      req_wb = 1'($urandom);
      op_ready = ($urandom_range(0, 3) != 0);
      wb_valid = 1'($urandom);
      wb_data = 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      step;
    end
    rst_n = 1'b1;
    step;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
